// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage: request side driven by the stage,
// completion (ready/rdata) driven by memory.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a req/ready port, stalls upstream
// while an access is outstanding, registers results for writeback.
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              is_write_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [RD_W-1:0]   register_d_in,
  output logic              stall_out,
  mem_stage_if.master       mem,
  output logic              wb_valid_out,
  output logic              wb_write_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [RD_W-1:0]   wb_reg_out,
  output logic              misalign_out
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_W-1:0]   rd_q;
  logic              write_q;
  logic              store_q;

  logic mem_op;
  logic aligned;
  logic mem_op_aligned;
  logic in_access;

  always_comb begin
    mem_op         = valid_in & (is_load_in | is_store_in);
    aligned        = (alu_result_in[1:0] == 2'b00);
    mem_op_aligned = mem_op & aligned;
    in_access      = (state == ACCESS);
    stall_out      = ((state == IDLE) & mem_op_aligned) | (in_access & ~mem.mem_ready);
  end

  // Memory port is a pure decode of state: nothing leaks out while IDLE.
  assign mem.mem_req   = in_access;
  assign mem.mem_we    = in_access & store_q;
  assign mem.mem_addr  = in_access ? addr_q  : '0;
  assign mem.mem_wdata = in_access ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      write_q      <= 1'b0;
      store_q      <= 1'b0;
      wb_valid_out <= 1'b0;
      wb_write_out <= 1'b0;
      wb_data_out  <= '0;
      wb_reg_out   <= '0;
      misalign_out <= 1'b0;
    end else begin
      misalign_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!valid_in) begin
            wb_valid_out <= 1'b0;
            wb_write_out <= 1'b0;
          end else if (!mem_op) begin
            wb_valid_out <= 1'b1;
            wb_data_out  <= alu_result_in;
            wb_reg_out   <= register_d_in;
            wb_write_out <= is_write_in & (register_d_in != '0);
          end else if (!aligned) begin
            // Misaligned access is dropped but still retires, without a write.
            wb_valid_out <= 1'b1;
            wb_data_out  <= alu_result_in;
            wb_reg_out   <= register_d_in;
            wb_write_out <= 1'b0;
            misalign_out <= 1'b1;
          end else begin
            addr_q       <= {alu_result_in[DATA_W-1:2], 2'b00};
            wdata_q      <= store_data_in;
            rd_q         <= register_d_in;
            write_q      <= is_write_in;
            store_q      <= is_store_in;
            wb_valid_out <= 1'b0;
            wb_write_out <= 1'b0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem.mem_ready) begin
            wb_valid_out <= 1'b1;
            wb_reg_out   <= rd_q;
            if (store_q) begin
              wb_write_out <= 1'b0;
              wb_data_out  <= addr_q;
            end else begin
              wb_write_out <= write_q & (rd_q != '0);
              wb_data_out  <= mem.mem_rdata;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal checks, plus a transaction
// model compared against every output on each falling edge.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        is_write_in;
  logic        is_load_in;
  logic        is_store_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  register_d_in;
  logic        stall_out;
  logic        wb_valid_out;
  logic        wb_write_out;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        misalign_out;

  mem_stage_if #(.DATA_W(32)) mif ();

  mem_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .is_write_in   (is_write_in),
    .is_load_in    (is_load_in),
    .is_store_in   (is_store_in),
    .alu_result_in (alu_result_in),
    .store_data_in (store_data_in),
    .register_d_in (register_d_in),
    .stall_out     (stall_out),
    .mem           (mif.master),
    .wb_valid_out  (wb_valid_out),
    .wb_write_out  (wb_write_out),
    .wb_data_out   (wb_data_out),
    .wb_reg_out    (wb_reg_out),
    .misalign_out  (misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one optional in-flight access plus the last retired result.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
    logic        st;
  } op_t;

  bit          model_live = 0;
  bit          pend;
  op_t         pop;
  logic        m_valid, m_write, m_mis;
  logic [31:0] m_data;
  logic [4:0]  m_reg;

  function automatic bit is_mem_op();
    return valid_in && (is_load_in || is_store_in);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_live = 1;
      pend = 0; pop = '0;
      m_valid = 0; m_write = 0; m_mis = 0; m_data = 0; m_reg = 0;
    end else if (pend) begin
      m_mis = 0;
      if (mif.mem_ready) begin
        pend    = 0;
        m_valid = 1;
        m_reg   = pop.rd;
        m_data  = pop.st ? pop.addr : mif.mem_rdata;
        m_write = !pop.st && pop.wr && (pop.rd != 0);
      end
    end else begin
      m_mis = 0;
      if (!valid_in) begin
        m_valid = 0; m_write = 0;
      end else if (is_mem_op() && alu_result_in % 4 == 0) begin
        pend = 1;
        pop  = '{addr: alu_result_in, data: store_data_in, rd: register_d_in,
                 wr: is_write_in, st: is_store_in};
        m_valid = 0; m_write = 0;
      end else begin
        m_valid = 1;
        m_data  = alu_result_in;
        m_reg   = register_d_in;
        m_mis   = is_mem_op();
        m_write = !is_mem_op() && is_write_in && (register_d_in != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_stall", stall_out,
            pend ? !mif.mem_ready : (is_mem_op() && alu_result_in % 4 == 0));
      check("m_req",   mif.mem_req,   pend);
      check("m_we",    mif.mem_we,    pend && pop.st);
      check("m_addr",  mif.mem_addr,  pend ? pop.addr : 32'h0);
      check("m_wdata", mif.mem_wdata, pend ? pop.data : 32'h0);
      check("m_wbv",   wb_valid_out,  m_valid);
      check("m_wbw",   wb_write_out,  m_write);
      check("m_mis",   misalign_out,  m_mis);
      if (m_valid) begin
        check("m_wbd", wb_data_out, m_data);
        check("m_wbr", wb_reg_out,  m_reg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic wr, input logic ld, input logic st,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    valid_in = v; is_write_in = wr; is_load_in = ld; is_store_in = st;
    alu_result_in = alu; store_data_in = sd; register_d_in = rd;
  endtask

  task automatic idle_in();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic rand_in();
    set_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, 5'($urandom));
    mif.mem_ready = 1'($urandom);
    mif.mem_rdata = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rand_in();
    tick();
    rand_in();
    tick();
    // Reset
    reset = 1'b0;
    idle_in();
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;
    #1;
    check("rst_stall", stall_out, 0);
    check("rst_req",   mif.mem_req, 0);
    check("rst_we",    mif.mem_we, 0);
    check("rst_addr",  mif.mem_addr, 0);
    check("rst_wdata", mif.mem_wdata, 0);
    check("rst_wbv",   wb_valid_out, 0);
    check("rst_wbw",   wb_write_out, 0);
    check("rst_wbd",   wb_data_out, 0);
    check("rst_wbr",   wb_reg_out, 0);
    check("rst_mis",   misalign_out, 0);
    tick();

    // ALU op, then same with rd=0
    set_op(1, 1, 0, 0, 32'h0000_1234, 32'h0, 5'd7);
    #1 check("alu_stall", stall_out, 0);
    tick();
    set_op(1, 1, 0, 0, 32'h0000_1234, 32'h0, 5'd0);
    #1;
    check("alu_wbv", wb_valid_out, 1);
    check("alu_wbw", wb_write_out, 1);
    check("alu_wbd", wb_data_out, 32'h0000_1234);
    check("alu_wbr", wb_reg_out, 7);
    check("alu_stall2", stall_out, 0);
    tick();
    idle_in();
    #1;
    check("alu0_wbv", wb_valid_out, 1);
    check("alu0_wbw", wb_write_out, 0);
    tick();

    // Load, ready in cycle 3
    set_op(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd5);
    #1;
    check("ld_c0_stall", stall_out, 1);
    check("ld_c0_req", mif.mem_req, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      mif.mem_ready = (c == 3);
      mif.mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      #1;
      check("ld_stall", stall_out, (c == 3) ? 0 : 1);
      check("ld_req",   mif.mem_req, 1);
      check("ld_addr",  mif.mem_addr, 32'h0000_0100);
      check("ld_we",    mif.mem_we, 0);
      check("ld_wbv",   wb_valid_out, 0);
    end
    tick();
    idle_in();
    mif.mem_ready = 1'b0;
    #1;
    check("ld_c4_wbv", wb_valid_out, 1);
    check("ld_c4_wbd", wb_data_out, 32'hDEAD_BEEF);
    check("ld_c4_wbr", wb_reg_out, 5);
    check("ld_c4_wbw", wb_write_out, 1);
    check("ld_c4_req", mif.mem_req, 0);
    tick();

    // Store, zero-wait (ready high in IDLE must be ignored)
    set_op(1, 0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 5'd3);
    mif.mem_ready = 1'b1;
    #1;
    check("st_c0_stall", stall_out, 1);
    check("st_c0_req", mif.mem_req, 0);
    tick();
    #1;
    check("st_c1_stall", stall_out, 0);
    check("st_c1_req",   mif.mem_req, 1);
    check("st_c1_we",    mif.mem_we, 1);
    check("st_c1_wdata", mif.mem_wdata, 32'hCAFE_F00D);
    check("st_c1_addr",  mif.mem_addr, 32'h0000_0200);
    tick();
    idle_in();
    #1;
    check("st_c2_wbv", wb_valid_out, 1);
    check("st_c2_wbw", wb_write_out, 0);
    check("st_c2_wbd", wb_data_out, 32'h0000_0200);
    check("st_c2_req", mif.mem_req, 0);
    tick();

    // Load with 1-cycle memory and rd=0: no register write
    set_op(1, 1, 1, 0, 32'h0000_0040, 32'h0, 5'd0);
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h0BAD_F00D;
    tick();
    #1 check("ld0_stall", stall_out, 0);
    tick();
    idle_in();
    mif.mem_ready = 1'b0;
    #1;
    check("ld0_wbv", wb_valid_out, 1);
    check("ld0_wbw", wb_write_out, 0);
    check("ld0_wbd", wb_data_out, 32'h0BAD_F00D);
    tick();

    // Misaligned load
    set_op(1, 1, 1, 0, 32'h0000_0103, 32'h0, 5'd6);
    #1;
    check("mis_c0_stall", stall_out, 0);
    check("mis_c0_req", mif.mem_req, 0);
    tick();
    idle_in();
    #1;
    check("mis_c1_req", mif.mem_req, 0);
    check("mis_c1_mis", misalign_out, 1);
    check("mis_c1_wbv", wb_valid_out, 1);
    check("mis_c1_wbw", wb_write_out, 0);
    check("mis_c1_wbd", wb_data_out, 32'h0000_0103);
    check("mis_c1_wbr", wb_reg_out, 6);
    tick();
    #1;
    check("mis_c2_mis", misalign_out, 0);
    check("mis_c2_req", mif.mem_req, 0);
    tick();

    // Reset during a pending load
    set_op(1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd4);
    tick();
    #1 check("rma_c1_req", mif.mem_req, 1);
    tick();
    reset = 1'b1;
    #1 check("rma_c2_req", mif.mem_req, 1);
    tick();
    reset = 1'b0;
    idle_in();
    mif.mem_ready = 1'b1;
    #1;
    check("rma_c3_req",   mif.mem_req, 0);
    check("rma_c3_wbv",   wb_valid_out, 0);
    check("rma_c3_stall", stall_out, 0);
    tick();
    mif.mem_ready = 1'b0;
    set_op(1, 1, 0, 0, 32'h0000_ABCD, 32'h0, 5'd2);
    #1 check("rma_c4_wbv", wb_valid_out, 0);
    tick();
    idle_in();
    #1;
    check("post_wbv", wb_valid_out, 1);
    check("post_wbw", wb_write_out, 1);
    check("post_wbd", wb_data_out, 32'h0000_ABCD);
    check("post_wbr", wb_reg_out, 2);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
